// File: rtl/wb_commit_if.sv
// wb_commit_if: bundles the writeback-stage request, the MDU result
// handshake and the register-file / CSR / commit outputs of the
// end-of-pipeline commit arbiter.
//   master : producer side (writeback stage + MDU); drives requests,
//            observes ready signals and write/commit outputs.
//   slave  : the arbiter; accepts requests, drives ready signals and the
//            registered rf_* / csr_* / commit_* outputs.
interface wb_commit_if #(
    parameter int DW = 64
);
    // writeback stage
    logic          wb_valid;
    logic          wb_ready;
    logic [63:0]   wb_pc;
    logic          wb_skip;
    logic          wb_regwrite;
    logic [4:0]    wb_dst;
    logic [DW-1:0] wb_regdata;
    logic          wb_csrwrite;
    logic [11:0]   wb_csr_dst;
    logic [DW-1:0] wb_csrdata;
    // multi-cycle unit result
    logic          mdu_valid;
    logic          mdu_ready;
    logic [4:0]    mdu_dst;
    logic [DW-1:0] mdu_data;
    // register file write port
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    // CSR write port
    logic          csr_we;
    logic [11:0]   csr_waddr;
    logic [DW-1:0] csr_wdata;
    // retire pulse
    logic          commit_valid;
    logic [63:0]   commit_pc;
    logic          commit_skip;

    modport master (
        output wb_valid, wb_pc, wb_skip, wb_regwrite, wb_dst, wb_regdata,
               wb_csrwrite, wb_csr_dst, wb_csrdata,
               mdu_valid, mdu_dst, mdu_data,
        input  wb_ready, mdu_ready,
               rf_we, rf_waddr, rf_wdata, csr_we, csr_waddr, csr_wdata,
               commit_valid, commit_pc, commit_skip
    );

    modport slave (
        input  wb_valid, wb_pc, wb_skip, wb_regwrite, wb_dst, wb_regdata,
               wb_csrwrite, wb_csr_dst, wb_csrdata,
               mdu_valid, mdu_dst, mdu_data,
        output wb_ready, mdu_ready,
               rf_we, rf_waddr, rf_wdata, csr_we, csr_waddr, csr_wdata,
               commit_valid, commit_pc, commit_skip
    );
endinterface

// File: rtl/wb_commit_arbiter.sv
// wb_commit_arbiter: owns the single integer register-file write port and
// the CSR write port. Each cycle the port goes either to the writeback
// instruction or to a one-entry buffered MDU result. The held result
// yields to pipeline writes for at most STARVE_LIMIT cycles, after which
// the pipeline is stalled for one cycle so the result can drain.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-low reset
//   bus   : wb_commit_if.slave (wb_* request, mdu_* result, rf_*/csr_*/
//           commit_* registered outputs, wb_ready/mdu_ready combinational)
module wb_commit_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DW           = 64
) (
    input  logic        clk,
    input  logic        reset,
    wb_commit_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, HOLD, FORCE} arbState_e;

    arbState_e     state, stateNext;
    logic [CW-1:0] starveCnt, cntNext;
    logic [4:0]    holdDst;
    logic [DW-1:0] holdData;

    logic wNeed, pend, wbReady, drain, mduReady, wAccept, load, wWrite;
    logic pendNext;

    always_comb begin
        wNeed    = bus.wb_valid & bus.wb_regwrite & (bus.wb_dst != 5'd0);
        pend     = (state != IDLE);
        wbReady  = (state != FORCE);
        // In HOLD the pipeline wins only when it really needs the port;
        // any cycle it does not (bubble, no regwrite, x0) drains the MDU.
        drain    = (state == FORCE) | ((state == HOLD) & ~wNeed);
        mduReady = ~pend | drain;
        wAccept  = bus.wb_valid & wbReady;
        wWrite   = wAccept & wNeed;
        load     = bus.mdu_valid & mduReady;

        // Counter only advances while the held result is losing to W.
        cntNext = '0;
        if (pend && !drain)
            cntNext = (starveCnt == CNT_MAX) ? starveCnt : starveCnt + 1'b1;

        pendNext = load | (pend & ~drain);
        if (!pendNext)
            stateNext = IDLE;
        else if (cntNext == CNT_MAX)
            stateNext = FORCE;
        else
            stateNext = HOLD;
    end

    assign bus.wb_ready  = wbReady;
    assign bus.mdu_ready = mduReady;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            starveCnt        <= '0;
            holdDst          <= '0;
            holdData         <= '0;
            bus.rf_we        <= 1'b0;
            bus.rf_waddr     <= '0;
            bus.rf_wdata     <= '0;
            bus.csr_we       <= 1'b0;
            bus.csr_waddr    <= '0;
            bus.csr_wdata    <= '0;
            bus.commit_valid <= 1'b0;
            bus.commit_pc    <= '0;
            bus.commit_skip  <= 1'b0;
        end else begin
            state     <= stateNext;
            starveCnt <= cntNext;
            if (load) begin
                holdDst  <= bus.mdu_dst;
                holdData <= bus.mdu_data;
            end

            // drain and wWrite are mutually exclusive by construction.
            bus.rf_we <= wWrite | drain;
            if (drain) begin
                bus.rf_waddr <= holdDst;
                bus.rf_wdata <= holdData;
            end else if (wWrite) begin
                bus.rf_waddr <= bus.wb_dst;
                bus.rf_wdata <= bus.wb_regdata;
            end

            bus.csr_we <= wAccept & bus.wb_csrwrite;
            if (wAccept && bus.wb_csrwrite) begin
                bus.csr_waddr <= bus.wb_csr_dst;
                bus.csr_wdata <= bus.wb_csrdata;
            end

            bus.commit_valid <= wAccept;
            if (wAccept) begin
                bus.commit_pc   <= bus.wb_pc;
                bus.commit_skip <= bus.wb_skip;
            end
        end
    end
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Bench for wb_commit_arbiter: directed scenarios plus a randomized run
// compared against a behavioural model (held MDU result + count of cycles
// it has lost the port).
module tb_wb_commit_arbiter;
    localparam int LIM = 4;
    localparam int DW  = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_commit_if #(.DW(DW)) bus ();

    wb_commit_arbiter #(.STARVE_LIMIT(LIM), .DW(DW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // model state
    bit          mPend = 0;
    logic [4:0]  mDst = '0;
    logic [63:0] mData = '0;
    int          mWait = 0;
    // model expectations
    logic        eRfWe = 0, eCsrWe = 0, eCmtV = 0, eCmtSkip = 0;
    logic [4:0]  eRfAddr = '0;
    logic [11:0] eCsrAddr = '0;
    logic [63:0] eRfData = '0, eCsrData = '0, eCmtPc = '0;
    logic        eWbRdy = 1, eMduRdy = 1;
    // sampled combinational outputs
    logic        sWbRdy, sMduRdy;

    task automatic idle();
        bus.wb_valid = 0; bus.wb_regwrite = 0; bus.wb_csrwrite = 0;
        bus.wb_dst = 0; bus.wb_regdata = 0; bus.wb_csr_dst = 0;
        bus.wb_csrdata = 0; bus.wb_pc = 0; bus.wb_skip = 0;
        bus.mdu_valid = 0; bus.mdu_dst = 0; bus.mdu_data = 0;
    endtask

    // One clock: sample ready signals mid-cycle, advance the model, then
    // let the edge happen and leave time 1 unit after it.
    task automatic cyc();
        bit forced, acc, need, mduW;
        @(negedge clk);
        sWbRdy  = bus.wb_ready;
        sMduRdy = bus.mdu_ready;
        forced  = mPend && (mWait >= LIM);
        eWbRdy  = !forced;
        acc     = bus.wb_valid && eWbRdy;
        need    = bus.wb_valid && bus.wb_regwrite && (bus.wb_dst != 0);
        mduW    = mPend && !(acc && need);
        eMduRdy = !mPend || mduW;
        if (!reset) begin
            mPend = 0; mWait = 0; mDst = 0; mData = 0;
            eRfWe = 0; eRfAddr = 0; eRfData = 0;
            eCsrWe = 0; eCsrAddr = 0; eCsrData = 0;
            eCmtV = 0; eCmtPc = 0; eCmtSkip = 0;
        end else begin
            eRfWe = (acc && need) || mduW;
            if (mduW) begin eRfAddr = mDst; eRfData = mData; end
            else if (acc && need) begin eRfAddr = bus.wb_dst; eRfData = bus.wb_regdata; end
            eCsrWe = acc && bus.wb_csrwrite;
            if (eCsrWe) begin eCsrAddr = bus.wb_csr_dst; eCsrData = bus.wb_csrdata; end
            eCmtV = acc;
            if (acc) begin eCmtPc = bus.wb_pc; eCmtSkip = bus.wb_skip; end
            if (mduW) begin mPend = 0; mWait = 0; end
            else if (mPend) mWait++;
            if (bus.mdu_valid && eMduRdy) begin
                mPend = 1; mWait = 0; mDst = bus.mdu_dst; mData = bus.mdu_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 0;
        cyc(); cyc();
        reset = 1;
        checks++;
        if ({bus.rf_we, bus.csr_we, bus.commit_valid} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes got=%b want=000", {bus.rf_we, bus.csr_we, bus.commit_valid});
        end
        checks++;
        if ({bus.rf_waddr, bus.rf_wdata, bus.csr_waddr, bus.csr_wdata, bus.commit_pc, bus.commit_skip} !== '0) begin
            failures++; $display("FAIL reset_data got nonzero addr/data/pc");
        end
        checks++;
        if ({bus.wb_ready, bus.mdu_ready} !== 2'b11) begin
            failures++; $display("FAIL reset_ready got=%b want=11", {bus.wb_ready, bus.mdu_ready});
        end
    endtask

    task automatic test_pipeline();
        idle();
        bus.wb_valid = 1; bus.wb_regwrite = 1; bus.wb_dst = 5; bus.wb_regdata = 64'h11;
        for (int i = 0; i < 3; i++) begin
            bus.wb_pc = 64'h1000 + 64'(i * 4);
            cyc();
            checks++;
            if ({sWbRdy, bus.rf_we, bus.rf_waddr, bus.commit_valid} !== {1'b1, 1'b1, 5'd5, 1'b1} ||
                bus.rf_wdata !== 64'h11 || bus.commit_pc !== 64'h1000 + 64'(i * 4)) begin
                failures++;
                $display("FAIL pipeline[%0d] rdy=%b we=%b addr=%0d data=%h cv=%b pc=%h want 1 1 5 11 1 %h",
                         i, sWbRdy, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.commit_valid, bus.commit_pc,
                         64'h1000 + 64'(i * 4));
            end
        end
        idle();
        cyc();
        checks++;
        if ({bus.rf_we, bus.commit_valid} !== 2'b00) begin
            failures++; $display("FAIL pipeline_end got=%b want=00", {bus.rf_we, bus.commit_valid});
        end
    endtask

    task automatic test_x0_csr();
        idle();
        bus.wb_valid = 1; bus.wb_regwrite = 1; bus.wb_dst = 0; bus.wb_regdata = 64'hDEAD;
        cyc();
        checks++;
        if ({bus.rf_we, bus.commit_valid} !== 2'b01) begin
            failures++; $display("FAIL x0_write got we,cv=%b want=01", {bus.rf_we, bus.commit_valid});
        end
        idle();
        bus.wb_valid = 1; bus.wb_csrwrite = 1; bus.wb_csr_dst = 12'h300; bus.wb_csrdata = 64'h8;
        cyc();
        checks++;
        if (bus.csr_we !== 1'b1 || bus.csr_waddr !== 12'h300 || bus.csr_wdata !== 64'h8 ||
            bus.rf_we !== 1'b0 || bus.commit_valid !== 1'b1) begin
            failures++; $display("FAIL csr_write got we=%b addr=%h data=%h rf=%b cv=%b want 1 300 8 0 1",
                                 bus.csr_we, bus.csr_waddr, bus.csr_wdata, bus.rf_we, bus.commit_valid);
        end
        idle(); cyc();
    endtask

    task automatic test_mdu_idle();
        idle();
        bus.mdu_valid = 1; bus.mdu_dst = 7; bus.mdu_data = 64'hAB;
        cyc();
        checks++;
        if (sMduRdy !== 1'b1 || bus.rf_we !== 1'b0) begin
            failures++; $display("FAIL mdu_load got rdy=%b we=%b want 1 0", sMduRdy, bus.rf_we);
        end
        idle();
        cyc();
        checks++;
        if (sMduRdy !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 64'hAB ||
            bus.commit_valid !== 1'b0) begin
            failures++; $display("FAIL mdu_drain got rdy=%b we=%b addr=%0d data=%h cv=%b want 1 1 7 ab 0",
                                 sMduRdy, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.commit_valid);
        end
    endtask

    task automatic test_starvation();
        logic [63:0] pc = 64'h2000;
        int commits = 0;
        idle();
        bus.mdu_valid = 1; bus.mdu_dst = 7; bus.mdu_data = 64'h77;
        cyc();
        idle();
        bus.wb_valid = 1; bus.wb_regwrite = 1; bus.wb_dst = 3; bus.wb_regdata = 64'h33;
        for (int i = 0; i <= LIM + 1; i++) begin
            bus.wb_pc = pc;
            cyc();
            if (sWbRdy) pc += 4;
            if (bus.commit_valid) commits++;
            checks++;
            if (sWbRdy !== (i != LIM) || bus.rf_we !== 1'b1 ||
                bus.rf_waddr !== ((i == LIM) ? 5'd7 : 5'd3) || bus.commit_valid !== (i != LIM)) begin
                failures++;
                $display("FAIL starve[%0d] rdy=%b we=%b addr=%0d cv=%b want rdy=%b addr=%0d",
                         i, sWbRdy, bus.rf_we, bus.rf_waddr, bus.commit_valid, (i != LIM),
                         (i == LIM) ? 7 : 3);
            end
        end
        checks++;
        if (commits != LIM + 1 || bus.commit_pc !== 64'h2000 + 64'(LIM * 4)) begin
            failures++; $display("FAIL starve_commits got n=%0d pc=%h want n=%0d pc=%h",
                                 commits, bus.commit_pc, LIM + 1, 64'h2000 + 64'(LIM * 4));
        end
        idle(); cyc();
    endtask

    task automatic test_shared();
        idle();
        bus.mdu_valid = 1; bus.mdu_dst = 9; bus.mdu_data = 64'h99;
        cyc();
        idle();
        bus.wb_valid = 1; bus.wb_csrwrite = 1; bus.wb_csr_dst = 12'h341; bus.wb_csrdata = 64'hC0;
        bus.mdu_valid = 1; bus.mdu_dst = 10; bus.mdu_data = 64'h55;
        cyc();
        checks++;
        if (sMduRdy !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.csr_we !== 1'b1 ||
            bus.csr_waddr !== 12'h341 || bus.commit_valid !== 1'b1) begin
            failures++; $display("FAIL shared got rdy=%b we=%b addr=%0d csr=%b caddr=%h cv=%b want 1 1 9 1 341 1",
                                 sMduRdy, bus.rf_we, bus.rf_waddr, bus.csr_we, bus.csr_waddr, bus.commit_valid);
        end
        // Refilled entry must start from a zero starve count: LIM wins, then a stall.
        idle();
        bus.wb_valid = 1; bus.wb_regwrite = 1; bus.wb_dst = 4;
        for (int i = 0; i <= LIM; i++) begin
            cyc();
            checks++;
            if (sWbRdy !== (i != LIM)) begin
                failures++; $display("FAIL refill_cnt[%0d] rdy=%b want=%b", i, sWbRdy, (i != LIM));
            end
        end
        checks++;
        if (bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 64'h55) begin
            failures++; $display("FAIL refill_drain got addr=%0d data=%h want 10 55", bus.rf_waddr, bus.rf_wdata);
        end
        idle(); cyc();
    endtask

    task automatic test_reset_mid();
        int hits = 0;
        idle();
        bus.mdu_valid = 1; bus.mdu_dst = 12; bus.mdu_data = 64'hBAD;
        cyc();
        idle();
        bus.wb_valid = 1; bus.wb_regwrite = 1; bus.wb_dst = 2; bus.wb_pc = 64'h40;
        cyc(); cyc();
        idle();
        reset = 0;
        cyc();
        reset = 1;
        checks++;
        if ({bus.rf_we, bus.csr_we, bus.commit_valid, bus.rf_waddr, bus.commit_pc} !== '0) begin
            failures++; $display("FAIL reset_mid outputs got we=%b cv=%b addr=%0d pc=%h want all 0",
                                 bus.rf_we, bus.commit_valid, bus.rf_waddr, bus.commit_pc);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (bus.rf_we) hits++;
            checks++;
            if (sMduRdy !== 1'b1) begin
                failures++; $display("FAIL reset_mid_rdy[%0d] got=%b want=1", i, sMduRdy);
            end
        end
        checks++;
        if (hits != 0) begin
            failures++; $display("FAIL reset_mid_discard got rf_we count=%0d want=0", hits);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.wb_valid    = ($urandom_range(0, 9) < 7);
            bus.wb_regwrite = ($urandom_range(0, 3) != 0);
            bus.wb_dst      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.wb_regdata  = {$urandom, $urandom};
            bus.wb_csrwrite = ($urandom_range(0, 3) == 0);
            bus.wb_csr_dst  = 12'($urandom);
            bus.wb_csrdata  = {$urandom, $urandom};
            bus.wb_pc       = {32'h0, $urandom};
            bus.wb_skip     = 1'($urandom);
            bus.mdu_valid   = ($urandom_range(0, 9) < 3);
            bus.mdu_dst     = 5'($urandom);
            bus.mdu_data    = {$urandom, $urandom};
            reset           = ($urandom_range(0, 99) != 0);
            cyc();
            checks++;
            if ({sWbRdy, sMduRdy} !== {eWbRdy, eMduRdy}) begin
                failures++; $display("FAIL rand_ready[%0d] got=%b want=%b", i, {sWbRdy, sMduRdy}, {eWbRdy, eMduRdy});
            end
            checks++;
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.csr_we, bus.csr_waddr, bus.csr_wdata,
                 bus.commit_valid, bus.commit_pc, bus.commit_skip} !==
                {eRfWe, eRfAddr, eRfData, eCsrWe, eCsrAddr, eCsrData, eCmtV, eCmtPc, eCmtSkip}) begin
                failures++;
                $display("FAIL rand_out[%0d] rf=%b/%0d/%h csr=%b/%h/%h cm=%b/%h/%b want rf=%b/%0d/%h csr=%b/%h/%h cm=%b/%h/%b",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.csr_we, bus.csr_waddr, bus.csr_wdata,
                         bus.commit_valid, bus.commit_pc, bus.commit_skip,
                         eRfWe, eRfAddr, eRfData, eCsrWe, eCsrAddr, eCsrData, eCmtV, eCmtPc, eCmtSkip);
            end
        end
        reset = 1;
        idle();
    endtask

    initial begin
        reset = 0;
        idle();
        test_reset();
        test_pipeline();
        test_x0_csr();
        test_mdu_idle();
        test_starvation();
        test_shared();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_commit_arbiter.md
# wb_commit_arbiter

Owns the single integer register-file write port and the CSR write port at the end of the pipeline. Every cycle it chooses between the writeback-stage result and a buffered multi-cycle (mul/div) unit result, and issues registered write strobes. It also emits a one-cycle commit pulse per retired pipeline instruction for the difftest/trace path. It sits between the writeback stage and the register file / CSR file, and back-pressures the pipeline only when a held MDU result has starved.

## Interface
- STARVE_LIMIT, default 4: blocked cycles a held MDU result tolerates before it forces the port (≥1).
- DW, default 64: register/CSR data width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- wb_valid  in  1  writeback stage holds an instruction.
- wb_ready  out  1  arbiter accepts the writeback instruction this cycle.
- wb_pc  in  64  PC of the writeback instruction.
- wb_skip  in  1  difftest skip flag.
- wb_regwrite / wb_dst / wb_regdata  in  1 / 5 / DW  integer write request.
- wb_csrwrite / wb_csr_dst / wb_csrdata  in  1 / 12 / DW  CSR write request.
- mdu_valid  in  1  MDU result available.
- mdu_ready  out  1  MDU result accepted into the hold register.
- mdu_dst / mdu_data  in  5 / DW  MDU destination and result.
- rf_we / rf_waddr / rf_wdata  out  1 / 5 / DW  register-file write, registered.
- csr_we / csr_waddr / csr_wdata  out  1 / 12 / DW  CSR write, registered.
- commit_valid / commit_pc / commit_skip  out  1 / 64 / 1  retire pulse, registered.

## Operation
- W_need = wb_valid & wb_regwrite & (wb_dst != 0). A write to x0 never uses the port and never generates rf_we.
- MDU hold register: one entry (pend, hdst, hdata). Load when mdu_valid & mdu_ready.
- mdu_ready = !pend | drain. A same-cycle drain and refill is legal.
- States:
  - IDLE: pend=0.
  - HOLD: pend=1, starve_cnt < STARVE_LIMIT.
  - FORCE: pend=1, starve_cnt == STARVE_LIMIT.
- Arbitration in HOLD: W wins if W_need. Otherwise drain (MDU writes).
- Arbitration in FORCE: drain, wb_ready=0.
- wb_ready = 1 in IDLE and HOLD, 0 in FORCE.
- An accepted W (wb_valid & wb_ready) always commits atomically: its reg write (if W_need), CSR write (if wb_csrwrite) and commit pulse all appear in the same output cycle.
- If W is accepted but does not need the reg port (no regwrite, or dst=0), a pending MDU result drains in the same cycle. The CSR write and the MDU reg write share that output cycle.
- starve_cnt:
  - Cleared on drain or when pend=0.
  - Incremented each cycle pend=1 and W wins.
  - Saturates at STARVE_LIMIT.
  - Width $clog2(STARVE_LIMIT+1).
- Transitions:
  - IDLE→HOLD on load.
  - HOLD→IDLE on drain without refill; HOLD→HOLD on drain with refill (counter cleared).
  - HOLD→FORCE when the counter reaches STARVE_LIMIT.
  - FORCE→IDLE or HOLD after the forced drain, depending on refill.
- Ordering between an MDU result and a younger writer of the same dst is guaranteed by the upstream scoreboard; the arbiter does not compare destinations.

## Timing
- Reset (reset=0 at a clock edge):
  - pend, starve_cnt cleared; state IDLE.
  - rf_we, csr_we, commit_valid = 0.
  - rf_waddr, rf_wdata, csr_waddr, csr_wdata, commit_pc, commit_skip = 0.
  - Reset asserted mid-HOLD discards the held MDU result.
- Latency: a request accepted in cycle t appears on rf_*/csr_*/commit_* in cycle t+1. Strobes are high for exactly one cycle per accepted request.
- Combinational paths: wb_ready depends only on state; mdu_ready depends on state and W_need.
- Worst-case MDU wait from load to write: STARVE_LIMIT+1 cycles.
- Back-to-back pipeline writes sustain one commit per cycle while pend=0.

## Test plan
- **Pipeline only:** wb_valid=1, regwrite=1, dst=5, data=0x11, 3 consecutive cycles, mdu_valid=0 → rf_we high 3 cycles starting t+1 with waddr=5, commit_valid each cycle, wb_ready always 1.
- **x0 and CSR:**
  - wb_dst=0 with regwrite=1 → rf_we stays 0, commit_valid=1.
  - wb_csrwrite=1, csr_dst=0x300, csrdata=0x8 → csr_we=1, csr_waddr=0x300 at t+1.
- **MDU idle-slot drain:** mdu_valid pulse (dst=7, data=0xAB) while wb_valid=0 → pend loads, rf_we with waddr=7/0xAB one cycle after drain, mdu_ready=1 throughout.
- **Starvation, STARVE_LIMIT=4:** MDU loads, then W_need continuously → W writes 4 cycles, then wb_ready=0 for exactly 1 cycle, MDU result written (dst=7), wb_ready returns to 1, W resumes with no lost or duplicated commit.
- **Shared cycle:** pend=1 and W with regwrite=0, csrwrite=1 → MDU reg write and W CSR write plus commit_valid in the same output cycle. mdu_valid asserted the same cycle → new result loads (refill), starve_cnt=0.
- **Reset mid-operation:** assert reset while pend=1, starve_cnt=2 → next cycle all outputs 0, mdu_ready=1; the discarded result never reaches rf_we.
